// File: rtl/tdd_sync_scheduler.sv
// -----------------------------------------------------------------------------
// tdd_sync_scheduler
//
// Frame-level scheduler feeding the sync_in input of one or more TDD sync
// buffers. Once armed it runs a frame counter and emits, per frame, a one-cycle
// sync pulse at a programmable offset, a gate window starting at that offset,
// and a frame-start marker. It runs a fixed number of frames or continuously.
//
// Optional feature macro: TDD_SYNC_SCHED_EXT_TRIG_EN
//   defined   : ARMED waits for a rising edge of i_ext_trig before RUN
//   undefined : ARMED lasts one cycle and i_ext_trig is unused
//
// Ports
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_enable       level enable, low forces IDLE
//   i_arm          one-cycle burst start request
//   i_ext_trig     external start trigger (feature macro only)
//   i_frame_len    frame length in cycles (>= 2)
//   i_sync_offset  sync pulse position in the frame (< frame length)
//   i_gate_len     gate window length, 0 = no gate
//   i_burst_count  frames per burst, 0 = continuous
//   o_sync_out     one-cycle sync pulse
//   o_gate_out     gate window
//   o_frame_start  one-cycle pulse at frame count 0
//   o_frame_idx    index of the current frame
//   o_busy         high while ARMED or RUN
//   o_done         one-cycle pulse when a finite burst completes
//   o_cfg_err      sticky flag, set when an arm is rejected
// -----------------------------------------------------------------------------
module tdd_sync_scheduler #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_enable,
    input  logic               i_arm,
    input  logic               i_ext_trig,
    input  logic [CNT_W-1:0]   i_frame_len,
    input  logic [CNT_W-1:0]   i_sync_offset,
    input  logic [CNT_W-1:0]   i_gate_len,
    input  logic [BURST_W-1:0] i_burst_count,
    output logic               o_sync_out,
    output logic               o_gate_out,
    output logic               o_frame_start,
    output logic [BURST_W-1:0] o_frame_idx,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [CNT_W-1:0]   r_frame_len;
    logic [CNT_W-1:0]   r_sync_offset;
    logic [CNT_W-1:0]   r_gate_len;
    logic [BURST_W-1:0] r_burst_count;
    logic [CNT_W-1:0]   r_cnt;
    logic [BURST_W-1:0] r_idx;
    logic               r_cfg_err;

    logic               r_sync_out;
    logic               r_gate_out;
    logic               r_frame_start;
    logic [BURST_W-1:0] r_frame_idx;
    logic               r_busy;
    logic               r_done;

    logic               w_cfg_valid;
    logic               w_frame_end;
    logic               w_last_frame;
    logic               w_trig_go;
    logic [CNT_W:0]     w_gate_end;
    logic               w_sync_out;
    logic               w_gate_out;
    logic               w_frame_start;
    logic               w_busy;
    logic               w_done;

    assign w_cfg_valid  = (i_frame_len >= CNT_W'(2)) && (i_sync_offset < i_frame_len);
    assign w_frame_end  = (r_cnt == r_frame_len - CNT_W'(1));
    assign w_last_frame = (r_burst_count != '0) && (r_idx == r_burst_count - BURST_W'(1));
    // One extra bit so a huge gate length cannot wrap past the offset.
    assign w_gate_end   = {1'b0, r_sync_offset} + {1'b0, r_gate_len};

`ifdef TDD_SYNC_SCHED_EXT_TRIG_EN
    logic r_trig_q1;
    logic r_trig_q2;

    // Edge detect on the registered trigger copy; a level already high when
    // arming shows no edge, so it cannot start the burst.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_trig_q1 <= 1'b0;
            r_trig_q2 <= 1'b0;
        end else begin
            r_trig_q1 <= i_ext_trig;
            r_trig_q2 <= r_trig_q1;
        end
    end

    assign w_trig_go = r_trig_q1 & ~r_trig_q2;
`else
    logic w_unused_ext_trig;
    assign w_unused_ext_trig = i_ext_trig;
    assign w_trig_go         = 1'b1;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a low enable overrides everything, including arm.
    always_comb begin
        w_next_state = r_state;
        if (!i_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_arm && w_cfg_valid) w_next_state = S_ARMED;
                S_ARMED: if (w_trig_go) w_next_state = S_RUN;
                S_RUN:   if (w_frame_end && w_last_frame) w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Config latch, sticky error flag, frame counter and frame index.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_frame_len   <= '0;
            r_sync_offset <= '0;
            r_gate_len    <= '0;
            r_burst_count <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_cfg_err     <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (i_arm) begin
                        if (w_cfg_valid) begin
                            r_frame_len   <= i_frame_len;
                            r_sync_offset <= i_sync_offset;
                            r_gate_len    <= i_gate_len;
                            r_burst_count <= i_burst_count;
                            r_cfg_err     <= 1'b0;
                        end else begin
                            r_cfg_err     <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (w_trig_go) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (w_frame_end) begin
                        if (!w_last_frame) begin
                            r_cnt <= '0;
                            r_idx <= r_idx + BURST_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the current state and count; registered below.
    always_comb begin
        w_frame_start = 1'b0;
        w_sync_out    = 1'b0;
        w_gate_out    = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        if (i_enable) begin
            w_busy = (r_state == S_ARMED) || (r_state == S_RUN);
            w_done = (r_state == S_DONE);
            if (r_state == S_RUN) begin
                w_frame_start = (r_cnt == '0);
                w_sync_out    = (r_cnt == r_sync_offset);
                w_gate_out    = (r_cnt >= r_sync_offset) && ({1'b0, r_cnt} < w_gate_end);
            end
        end
    end

    // Output registers; frame index freezes while disabled.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_frame_start <= 1'b0;
            r_sync_out    <= 1'b0;
            r_gate_out    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_idx   <= '0;
        end else begin
            r_frame_start <= w_frame_start;
            r_sync_out    <= w_sync_out;
            r_gate_out    <= w_gate_out;
            r_busy        <= w_busy;
            r_done        <= w_done;
            if (i_enable) begin
                r_frame_idx <= r_idx;
            end
        end
    end

    assign o_sync_out    = r_sync_out;
    assign o_gate_out    = r_gate_out;
    assign o_frame_start = r_frame_start;
    assign o_frame_idx   = r_frame_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_tdd_sync_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tdd_sync_scheduler
//
// Self-checking bench for tdd_sync_scheduler in the default build (external
// trigger feature macro TDD_SYNC_SCHED_EXT_TRIG_EN undefined). Expected output
// records come from a cycle-indexed model of a burst armed at cycle 0 and are
// queued, then compared each cycle one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_tdd_sync_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        arm;
    logic        ext_trig;
    logic [31:0] frame_len;
    logic [31:0] sync_offset;
    logic [31:0] gate_len;
    logic [15:0] burst_count;
    logic        sync_out;
    logic        gate_out;
    logic        frame_start;
    logic [15:0] frame_idx;
    logic        busy;
    logic        done;
    logic        cfg_err;

    typedef struct packed {
        logic        fs;
        logic        sync;
        logic        gate;
        logic [15:0] idx;
        logic        busy;
        logic        done;
        logic        cfg;
    } outRec_t;

    typedef struct {
        longint L;
        longint O;
        longint G;
        longint B;
        longint expDoneAt;
        longint expGateCycles;
    } vec_t;

    outRec_t     expQ[$];
    int          checks   = 0;
    int          failures = 0;
    vec_t        vecs[6];
    logic [15:0] prevIdx;

    always #5 clk = ~clk;

    tdd_sync_scheduler #(.CNT_W(32), .BURST_W(16)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_enable      (enable),
        .i_arm         (arm),
        .i_ext_trig    (ext_trig),
        .i_frame_len   (frame_len),
        .i_sync_offset (sync_offset),
        .i_gate_len    (gate_len),
        .i_burst_count (burst_count),
        .o_sync_out    (sync_out),
        .o_gate_out    (gate_out),
        .o_frame_start (frame_start),
        .o_frame_idx   (frame_idx),
        .o_busy        (busy),
        .o_done        (done),
        .o_cfg_err     (cfg_err)
    );

    // Guards against a run that never reaches its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected outputs at cycle t for a burst armed (valid config) at cycle 0.
    function automatic outRec_t modelBurst(longint t, longint L, longint O, longint G,
                                           longint B, logic [15:0] pIdx);
        outRec_t r;
        longint  k;
        longint  pos;
        longint  endT;
        r     = '0;
        r.idx = pIdx;
        endT  = 2 + B * L;
        if (t >= 1 && (B == 0 || t < endT)) r.busy = 1'b1;
        if (t >= 2 && (B == 0 || t < endT)) begin
            k      = t - 2;
            pos    = k % L;
            r.fs   = (pos == 0);
            r.sync = (pos == O);
            r.gate = (pos >= O) && (pos < O + G);
            r.idx  = 16'(k / L);
        end
        if (B != 0 && t >= endT) begin
            r.idx  = 16'(B - 1);
            r.done = (t == endT);
        end
        return r;
    endfunction

    function automatic outRec_t idleRec(logic [15:0] idx, logic cfg);
        outRec_t r;
        r     = '0;
        r.idx = idx;
        r.cfg = cfg;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic en, input longint L,
                                 input longint O, input longint G, input longint B);
        arm         = a;
        enable      = en;
        frame_len   = 32'(L);
        sync_offset = 32'(O);
        gate_len    = 32'(G);
        burst_count = 16'(B);
    endtask

    task automatic checkOutput(input string name);
        outRec_t exp;
        outRec_t act;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        exp = expQ.pop_front();
        act = {frame_start, sync_out, gate_out, frame_idx, busy, done, cfg_err};
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got fs=%0b sync=%0b gate=%0b idx=%0d busy=%0b done=%0b cfg=%0b, expected fs=%0b sync=%0b gate=%0b idx=%0d busy=%0b done=%0b cfg=%0b",
                     name, act.fs, act.sync, act.gate, act.idx, act.busy, act.done, act.cfg,
                     exp.fs, exp.sync, exp.gate, exp.idx, exp.busy, exp.done, exp.cfg);
        end
    endtask

    task automatic step(input outRec_t exp, input string name);
        expQ.push_back(exp);
        tick();
        checkOutput(name);
    endtask

    // Full burst: arm at cycle 0, scramble the config inputs afterwards and
    // pulse arm (with an invalid config) while running; neither may matter.
    task automatic runBurst(input vec_t v, input int id, input logic [15:0] pIdx);
        longint doneAt;
        longint gateCnt;
        longint total;
        doneAt  = -1;
        gateCnt = 0;
        total   = v.B * v.L + 5;
        applyStimulus(1'b1, 1'b1, v.L, v.O, v.G, v.B);
        step(modelBurst(0, v.L, v.O, v.G, v.B, pIdx), $sformatf("vec%0d_t0", id));
        for (longint t = 1; t <= total; t++) begin
            applyStimulus((t == 4), 1'b1, 3, 9, 1, 1);
            step(modelBurst(t, v.L, v.O, v.G, v.B, pIdx), $sformatf("vec%0d_t%0d", id, t));
            if (done) doneAt = t;
            gateCnt += longint'(gate_out);
        end
        checks++;
        if (doneAt != v.expDoneAt) begin
            failures++;
            $display("[TB] FAIL vec%0d_done_cycle: got %0d, expected %0d", id, doneAt, v.expDoneAt);
        end
        checks++;
        if (gateCnt != v.expGateCycles) begin
            failures++;
            $display("[TB] FAIL vec%0d_gate_cycles: got %0d, expected %0d", id, gateCnt, v.expGateCycles);
        end
    endtask

    initial begin
        // L, O, G, B, done cycle, total gate cycles
        vecs[0] = '{10, 3, 4,             2, 22, 8};
        vecs[1] = '{ 8, 6, 5,             2, 18, 4};
        vecs[2] = '{ 5, 0, 0,             3, 17, 0};
        vecs[3] = '{ 2, 1, 1,             3,  8, 3};
        vecs[4] = '{ 6, 5, 100,           1,  8, 1};
        vecs[5] = '{ 6, 2, 64'hFFFF_FFFF, 2, 14, 8};

        ext_trig = 1'b0;
        rstn     = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
        tick();
        step(idleRec(16'd0, 1'b0), "reset_values");
        rstn = 1'b1;
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0);
        step(idleRec(16'd0, 1'b0), "idle_after_reset");

        // Table-driven finite bursts.
        prevIdx = 16'd0;
        for (int i = 0; i < 6; i++) begin
            runBurst(vecs[i], i, prevIdx);
            prevIdx = 16'(vecs[i].B - 1);
        end

        // Continuous mode for more than 100 frames, then disable mid-frame.
        applyStimulus(1'b1, 1'b1, 4, 1, 2, 0);
        step(modelBurst(0, 4, 1, 2, 0, prevIdx), "cont_t0");
        applyStimulus(1'b0, 1'b1, 3, 9, 1, 1);
        for (longint t = 1; t <= 422; t++) begin
            step(modelBurst(t, 4, 1, 2, 0, prevIdx), $sformatf("cont_t%0d", t));
        end
        applyStimulus(1'b0, 1'b0, 4, 1, 2, 0);
        for (int i = 0; i < 3; i++) step(idleRec(16'd105, 1'b0), $sformatf("cont_disable%0d", i));
        applyStimulus(1'b0, 1'b1, 4, 1, 2, 0);
        for (int i = 0; i < 2; i++) step(idleRec(16'd105, 1'b0), $sformatf("cont_reenable%0d", i));
        prevIdx = 16'd105;

        // Reset in the middle of the second frame.
        applyStimulus(1'b1, 1'b1, 10, 3, 4, 3);
        step(modelBurst(0, 10, 3, 4, 3, prevIdx), "rst_t0");
        applyStimulus(1'b0, 1'b1, 10, 3, 4, 3);
        for (longint t = 1; t <= 13; t++) begin
            step(modelBurst(t, 10, 3, 4, 3, prevIdx), $sformatf("rst_t%0d", t));
        end
        rstn = 1'b0;
        step(idleRec(16'd0, 1'b0), "rst_midburst");
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) step(idleRec(16'd0, 1'b0), $sformatf("rst_after%0d", i));

        // Arm coinciding with enable low: disable wins.
        applyStimulus(1'b1, 1'b0, 10, 3, 4, 2);
        for (int i = 0; i < 3; i++) step(idleRec(16'd0, 1'b0), $sformatf("arm_disabled%0d", i));
        applyStimulus(1'b0, 1'b1, 10, 3, 4, 2);
        for (int i = 0; i < 2; i++) step(idleRec(16'd0, 1'b0), $sformatf("arm_disabled_after%0d", i));

        // Rejected arms set the sticky error and never start a burst.
        applyStimulus(1'b1, 1'b1, 1, 0, 0, 1);
        step(idleRec(16'd0, 1'b1), "cfg_len1");
        applyStimulus(1'b0, 1'b1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(idleRec(16'd0, 1'b1), $sformatf("cfg_len1_hold%0d", i));
        applyStimulus(1'b1, 1'b1, 5, 5, 2, 1);
        step(idleRec(16'd0, 1'b1), "cfg_off_eq_len");
        applyStimulus(1'b0, 1'b1, 5, 5, 2, 1);
        for (int i = 0; i < 3; i++) step(idleRec(16'd0, 1'b1), $sformatf("cfg_off_hold%0d", i));
        rstn = 1'b0;
        step(idleRec(16'd0, 1'b0), "cfg_reset_clears");
        rstn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1, 0, 0, 1);
        step(idleRec(16'd0, 1'b1), "cfg_rearm_invalid");
        runBurst(vecs[0], 10, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdd_sync_scheduler.md
# tdd_sync_scheduler

Frame-level scheduler that drives the `sync_in` input of the TDD sync buffer. Once armed, it generates a periodic one-cycle sync pulse at a programmable offset inside each frame, plus a gate window and frame markers. It runs for a programmable number of frames, or continuously. It sits between the control/register layer and one or more TDD sync buffers.

## Interface
- `CNT_W`, 32, width of frame counter, `frame_len`, `sync_offset`, `gate_len`
- `BURST_W`, 16, width of `burst_count` and `frame_idx`

- `clk`  in  1  clock
- `rstn`  in  1  synchronous, active-low reset
- `enable`  in  1  level; low forces IDLE
- `arm`  in  1  one-cycle request to start a burst
- `ext_trig`  in  1  external start trigger (used only with `TDD_SYNC_SCHED_EXT_TRIG_EN`)
- `frame_len`  in  CNT_W  frame length in cycles
- `sync_offset`  in  CNT_W  cycle index of the sync pulse within a frame
- `gate_len`  in  CNT_W  gate window length in cycles; 0 means no gate
- `burst_count`  in  BURST_W  frames per burst; 0 means continuous
- `sync_out`  out  1  one-cycle pulse to the buffer `sync_in`
- `gate_out`  out  1  gate window
- `frame_start`  out  1  one-cycle pulse at frame counter 0
- `frame_idx`  out  BURST_W  index of the current frame
- `busy`  out  1  high in ARMED or RUN
- `done`  out  1  one-cycle pulse when a finite burst completes
- `cfg_err`  out  1  sticky; set on rejected `arm`

## Operation
- States and transitions:
  - IDLE: `arm && enable` with valid config latches all config inputs, clears `cfg_err`, and moves to ARMED.
  - ARMED: moves to RUN per Configuration.
  - RUN: frame counter `cnt` runs 0..`frame_len`-1, then wraps.
  - DONE: lasts one cycle, then IDLE.
- Config is valid when `frame_len` ≥ 2 and `sync_offset` < `frame_len`.
  - Invalid config on `arm`: set `cfg_err`, stay in IDLE.
  - Config inputs are ignored outside the latch cycle.
- `arm` outside IDLE is ignored. It has no effect on `cfg_err`.
- RUN decodes, all registered:
  - `frame_start` for `cnt`==0.
  - `sync_out` for `cnt`==`sync_offset`.
  - `gate_out` for `sync_offset` ≤ `cnt` < `sync_offset`+`gate_len`.
  - The gate is clipped at `frame_len`-1 and never spans frames. The sum is computed at CNT_W+1 bits, with no wrap.
- Frame end:
  - At `cnt`==`frame_len`-1: if `burst_count`≠0 and `frame_idx`==`burst_count`-1, go to DONE. Otherwise `cnt`←0 and `frame_idx`+1.
  - In continuous mode `frame_idx` wraps modulo 2^BURST_W.
- `enable` low in any state: go to IDLE next edge. All pulse and gate outputs are low from that edge. `done` is not asserted, and `frame_idx` holds.
- `frame_idx` clears to 0 on entry to RUN.
- `busy` = ARMED|RUN.

## Timing
- Reset values: state IDLE, `cnt`=0, `sync_out`=0, `gate_out`=0, `frame_start`=0, `frame_idx`=0, `busy`=0, `done`=0, `cfg_err`=0.
- All outputs are registered and update one edge after the internal counter reaches the decoded value.
- Macro off: `arm` sampled at edge E0 gives ARMED after E0, RUN/`cnt`=0 after E1, `frame_start` high after E2, and `sync_out` high after E2+`sync_offset`.
- Frame period is exactly `frame_len` cycles. `sync_out` is exactly one cycle wide.
- `done` is high for the one cycle after the last frame's final count. `busy` falls on the same edge.
- If `sync_offset`==0, `sync_out` and `frame_start` coincide.
- Reset mid-burst: all outputs return to reset values on the next edge, including sticky `cfg_err`.
- `arm` and `enable` falling on the same edge: disable wins.

## Configuration
- `TDD_SYNC_SCHED_EXT_TRIG_EN` defined:
  - ARMED waits for a rising edge of `ext_trig`, detected on a registered copy.
  - The edge moves the block to RUN on the next edge.
  - `ext_trig` already high when arming does not count as an edge.
  - Each burst needs a new arm and a new trigger.
- Undefined: ARMED lasts one cycle, `ext_trig` is unused, and no trigger logic is synthesized.

## Test plan
- `frame_len`=10, `sync_offset`=3, `gate_len`=4, `burst_count`=2, arm at cycle 0 (macro off) -> `frame_start` at 2 and 12, `sync_out` at 5 and 15, `gate_out` over 5–8 and 15–18, `done` at 22, `busy` low from 22.
- `frame_len`=8, `sync_offset`=6, `gate_len`=5 -> `gate_out` covers only `cnt` 6–7 of each frame, low at every `frame_start`.
- `burst_count`=0, `frame_len`=4 -> `sync_out` every 4 cycles for more than 100 frames, no `done`; deassert `enable` -> outputs low next edge, `busy`=0.
- Arm with `frame_len`=1, then with `sync_offset`=`frame_len`=5 -> `cfg_err`=1, state IDLE, no pulses; next valid arm clears `cfg_err`.
- Reset asserted mid-frame, and `arm` pulsed while RUN -> reset returns all outputs to 0 the next edge; the arm during RUN changes nothing.
- Macro on: arm, hold `ext_trig` high, then low, then high at cycle 20 -> first `frame_start` at 22, and no run before the rising edge.
